four_operand_serial_adder: RTL



---
 rtl/four_operand_serial_adder.sv | 116 +++++++++++
 1 files changed

// File: rtl/four_operand_serial_adder.sv
// Bit-serial four-operand adder: one six-input column cell reused over WIDTH+2 clocks,
// with parallel operand load and parallel result return on valid/ready handshakes.
module four_operand_serial_adder #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned SIGNED = 0
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic               op_valid_in,
    output logic               op_ready_out,
    input  logic [WIDTH-1:0]   a0_in,
    input  logic [WIDTH-1:0]   a1_in,
    input  logic [WIDTH-1:0]   a2_in,
    input  logic [WIDTH-1:0]   a3_in,
    output logic               sum_valid_out,
    input  logic               sum_ready_in,
    output logic [WIDTH+1:0]   sum_out,
    output logic               busy_out
);

    localparam int unsigned RW   = WIDTH + 2;
    localparam int unsigned CW   = $clog2(WIDTH + 2);
    localparam int unsigned LAST = WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] sh0_q, sh1_q, sh2_q, sh3_q;
    logic             c0_q;
    logic             c1_dly_q;
    logic             c1_q;
    logic [2:0]       col_c;
    logic             accept_c;

    // Right shift that refills the top with the sign bit (signed) or zero (unsigned),
    // so bit 0 naturally supplies the extension bits for columns WIDTH and WIDTH+1.
    function automatic logic [WIDTH-1:0] ext_shift(input logic [WIDTH-1:0] v);
        logic [WIDTH:0] t;
        t = {(SIGNED != 0) & v[WIDTH-1], v};
        return t[WIDTH:1];
    endfunction

    assign accept_c = (state_q == IDLE) && op_valid_in;

    // Six-input column cell: four operand bits plus weight-2 and weight-4 carries.
    always_comb begin
        col_c = 3'(sh0_q[0]) + 3'(sh1_q[0]) + 3'(sh2_q[0]) + 3'(sh3_q[0])
              + 3'(c0_q) + 3'(c1_q);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (op_valid_in)             state_d = RUN;
            RUN:     if (cnt_q == CW'(LAST))      state_d = DONE;
            DONE:    if (sum_ready_in)            state_d = IDLE;
            default:                              state_d = IDLE;
        endcase
    end

    // State register with the handshake flags registered from the next state.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q       <= IDLE;
            op_ready_out  <= 1'b1;
            sum_valid_out <= 1'b0;
            busy_out      <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_ready_out  <= (state_d == IDLE);
            sum_valid_out <= (state_d == DONE);
            busy_out      <= (state_d != IDLE);
        end
    end

    // Serial datapath: operand shifters, carry registers, result shifter, column counter.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sh0_q    <= '0;
            sh1_q    <= '0;
            sh2_q    <= '0;
            sh3_q    <= '0;
            c0_q     <= 1'b0;
            c1_dly_q <= 1'b0;
            c1_q     <= 1'b0;
            cnt_q    <= '0;
            sum_out  <= '0;
        end else if (accept_c) begin
            sh0_q    <= a0_in;
            sh1_q    <= a1_in;
            sh2_q    <= a2_in;
            sh3_q    <= a3_in;
            c0_q     <= 1'b0;
            c1_dly_q <= 1'b0;
            c1_q     <= 1'b0;
            cnt_q    <= '0;
        end else if (state_q == RUN) begin
            sh0_q    <= ext_shift(sh0_q);
            sh1_q    <= ext_shift(sh1_q);
            sh2_q    <= ext_shift(sh2_q);
            sh3_q    <= ext_shift(sh3_q);
            c0_q     <= col_c[1];
            c1_dly_q <= col_c[2];
            c1_q     <= c1_dly_q;
            cnt_q    <= cnt_q + CW'(1);
            sum_out  <= {col_c[0], sum_out[RW-1:1]};
        end
    end

endmodule
